// File: rtl/truth_table_sweeper_pkg.sv
// tt_sweep_pkg: shared state encoding, row count and truth-table bit ordering
package tt_sweep_pkg;
   localparam int NUM_ROWS = 8;
   localparam logic [2:0] LAST_ROW = 3'(NUM_ROWS - 1);
   typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, FINISH} state_t;
   function automatic logic [2:0] row_bit(input logic [2:0] row);
      return LAST_ROW - row;
   endfunction
endpackage

// File: rtl/truth_table_sweeper_if.sv
// truth_table_sweeper_if: start/result handshake plus in1/in2/in3 -> out link to the function-under-test
interface truth_table_sweeper_if;
   logic       start;
   logic       in1;
   logic       in2;
   logic       in3;
   logic       out;
   logic       busy;
   logic       done;
   logic       match;
   logic [7:0] code;
   logic [7:0] mismatch;
   modport master (input start, out, output in1, in2, in3, busy, done, code, match, mismatch);
   modport slave  (output start, out, input in1, in2, in3, busy, done, code, match, mismatch);
endinterface

// File: rtl/truth_table_sweeper_timer.sv
// tt_settle_timer: loadable down-counter; expired marks the last settle cycle of a row
module tt_settle_timer #(
   parameter int SETTLE_CYCLES = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic i_load,
   output logic o_expired
);
   logic [7:0] r_cnt;
   // load on entry to SETTLE so the counter reaches zero after SETTLE_CYCLES cycles
   always_ff @(posedge clk)
      if (reset) r_cnt <= '0;
      else if (i_load) r_cnt <= 8'(SETTLE_CYCLES - 1);
      else if (r_cnt != 8'd0) r_cnt <= r_cnt - 8'd1;
   assign o_expired = (r_cnt == 8'd0);
endmodule

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: drives all eight rows into a 3-input function and captures its truth-table code
module truth_table_sweeper
   import tt_sweep_pkg::*;
#(
   parameter int         SETTLE_CYCLES = 4,
   parameter logic [7:0] EXPECTED      = 8'hC2
) (
   input  logic                  clk,
   input  logic                  reset,
   truth_table_sweeper_if.master bus
);
   state_t     r_state;
   logic [2:0] r_row;
   logic [7:0] r_code;
   logic [7:0] r_mismatch;
   logic       r_match;
   logic       r_busy;
   logic       r_done;
   logic [7:0] w_code_next;
   logic       w_load;
   logic       w_expired;
   logic       w_last;
   assign w_last = (r_row == LAST_ROW);
   assign w_load = (r_state == IDLE && bus.start) || (r_state == SAMPLE && !w_last);
   tt_settle_timer #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_timer (
      .clk       (clk),
      .reset     (reset),
      .i_load    (w_load),
      .o_expired (w_expired)
   );
   // code with the current row's sample merged in, so match can be judged on the final sample edge
   always_comb begin
      w_code_next = r_code;
      w_code_next[row_bit(r_row)] = bus.out;
   end
   // sweep FSM; rows return to 000 after the last sample so IDLE always presents 000
   always_ff @(posedge clk)
      if (reset) begin
         r_state    <= IDLE;
         r_row      <= '0;
         r_code     <= '0;
         r_match    <= 1'b0;
         r_mismatch <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         case (r_state)
            IDLE: if (bus.start) begin
               r_state    <= SETTLE;
               r_row      <= '0;
               r_code     <= '0;
               r_match    <= 1'b0;
               r_mismatch <= '0;
               r_busy     <= 1'b1;
            end
            SETTLE: if (w_expired) r_state <= SAMPLE;
            SAMPLE: begin
               r_code <= w_code_next;
               if (w_last) begin
                  r_state    <= FINISH;
                  r_row      <= '0;
                  r_done     <= 1'b1;
                  r_match    <= (w_code_next == EXPECTED);
                  r_mismatch <= w_code_next ^ EXPECTED;
               end else begin
                  r_state <= SETTLE;
                  r_row   <= r_row + 3'd1;
               end
            end
            FINISH: begin
               r_state <= IDLE;
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
            end
            default: r_state <= IDLE;
         endcase
      end
   assign {bus.in1, bus.in2, bus.in3} = r_row;
   assign bus.busy     = r_busy;
   assign bus.done     = r_done;
   assign bus.code     = r_code;
   assign bus.match    = r_match;
   assign bus.mismatch = r_mismatch;
endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb_truth_table_sweeper: directed and random sweeps against a row-by-row reference of the truth table
module tb_truth_table_sweeper;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   int         checks = 0;
   int         errors = 0;
   logic       start_d [2];
   int         mode [2];
   logic [7:0] fut [2];
   logic [2:0] rows [2];
   logic       busy_o [2];
   logic       done_o [2];
   logic       match_o [2];
   logic [7:0] code_o [2];
   logic [7:0] mism_o [2];

   truth_table_sweeper_if if0 ();
   truth_table_sweeper_if if1 ();

   truth_table_sweeper #(.SETTLE_CYCLES(4), .EXPECTED(8'hC2)) u0 (.clk(clk), .reset(reset), .bus(if0.master));
   truth_table_sweeper #(.SETTLE_CYCLES(1), .EXPECTED(8'hC2)) u1 (.clk(clk), .reset(reset), .bus(if1.master));

   always #5 clk = ~clk;

   // function-under-test: 0 = table lookup, 1 = constant one, 2 = in1 ^ in3
   function automatic logic fut_out(input int m, input logic [7:0] t, input logic [2:0] r);
      return (m == 1) ? 1'b1 : (m == 2) ? (r[2] ^ r[0]) : t[3'd7 - r];
   endfunction

   function automatic logic [7:0] ref_code(input int m, input logic [7:0] t);
      logic [7:0] c = '0;
      for (int k = 0; k < 8; k++) c[7 - k] = fut_out(m, t, 3'(k));
      return c;
   endfunction

   assign if0.start = start_d[0];
   assign if1.start = start_d[1];
   assign if0.out = fut_out(mode[0], fut[0], {if0.in1, if0.in2, if0.in3});
   assign if1.out = fut_out(mode[1], fut[1], {if1.in1, if1.in2, if1.in3});
   assign rows[0] = {if0.in1, if0.in2, if0.in3};
   assign rows[1] = {if1.in1, if1.in2, if1.in3};
   assign busy_o[0] = if0.busy;
   assign busy_o[1] = if1.busy;
   assign done_o[0] = if0.done;
   assign done_o[1] = if1.done;
   assign match_o[0] = if0.match;
   assign match_o[1] = if1.match;
   assign code_o[0] = if0.code;
   assign code_o[1] = if1.code;
   assign mism_o[0] = if0.mismatch;
   assign mism_o[1] = if1.mismatch;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // called at a negedge with the unit idle; returns at the negedge of the cycle after done
   task automatic sweep(input int u, input int m, input logic [7:0] t, input bit ping, input string tag);
      int s = (u == 0) ? 4 : 1;
      int last = 8 * (s + 1);
      logic [7:0] ec = ref_code(m, t);
      int bad = 0;
      mode[u] = m;
      fut[u] = t;
      start_d[u] = 1'b1;
      @(negedge clk);
      start_d[u] = 1'b0;
      chk({tag, "_clr_code"}, code_o[u], 0);
      chk({tag, "_clr_match"}, {match_o[u], mism_o[u]}, 0);
      for (int c = 1; c <= last; c++) begin
         if (c > 1) @(negedge clk);
         if (rows[u] !== 3'((c - 1) / (s + 1)) || busy_o[u] !== 1'b1 || done_o[u] !== 1'b0) bad++;
         start_d[u] = ping && (c == 5);
      end
      start_d[u] = 1'b0;
      chk({tag, "_row_seq"}, bad, 0);
      @(negedge clk);
      chk({tag, "_done"}, {done_o[u], busy_o[u]}, 2'b11);
      chk({tag, "_code"}, code_o[u], ec);
      chk({tag, "_match"}, match_o[u], ec == 8'hC2);
      chk({tag, "_mismatch"}, mism_o[u], ec ^ 8'hC2);
      @(negedge clk);
      chk({tag, "_idle"}, {done_o[u], busy_o[u], rows[u]}, 0);
      chk({tag, "_held"}, code_o[u], ec);
   endtask

   initial begin
      int cnt;
      logic [7:0] t;
      start_d[0] = 1'b0;
      start_d[1] = 1'b0;
      mode[0] = 0;
      mode[1] = 0;
      fut[0] = 8'h00;
      fut[1] = 8'h00;
      repeat (3) @(negedge clk);
      for (int u = 0; u < 2; u++)
         chk("reset_state", {rows[u], busy_o[u], done_o[u], match_o[u], code_o[u], mism_o[u]}, 0);
      reset = 1'b0;
      @(negedge clk);
      sweep(0, 0, 8'hC2, 1'b0, "c2");
      sweep(0, 1, 8'h00, 1'b0, "const1");
      chk("const1_lit", {code_o[0], mism_o[0]}, 16'hFF3D);
      sweep(1, 2, 8'h00, 1'b1, "xor_s1");
      chk("xor_lit", code_o[1], 8'h5A);
      cnt = 0;
      repeat (20) begin
         @(negedge clk);
         if (done_o[1] !== 1'b0 || busy_o[1] !== 1'b0) cnt++;
      end
      chk("xor_no_resweep", cnt, 0);
      mode[0] = 0;
      fut[0] = 8'hC2;
      start_d[0] = 1'b1;
      @(negedge clk);
      start_d[0] = 1'b0;
      repeat (16) @(negedge clk);
      chk("rst_pre_row", rows[0], 3);
      chk("rst_pre_code", code_o[0], 8'hC0);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("rst_idle", {rows[0], busy_o[0], done_o[0], code_o[0], match_o[0], mism_o[0]}, 0);
      cnt = 0;
      repeat (50) begin
         @(negedge clk);
         if (done_o[0] !== 1'b0 || busy_o[0] !== 1'b0) cnt++;
      end
      chk("rst_no_done", cnt, 0);
      sweep(0, 0, 8'hC2, 1'b0, "after_rst");
      sweep(0, 0, 8'hC2, 1'b0, "b2b_a");
      chk("b2b_hold", {code_o[0], match_o[0], mism_o[0]}, {8'hC2, 1'b1, 8'h00});
      sweep(0, 0, 8'h01, 1'b0, "b2b_b");
      chk("b2b_lit", {code_o[0], match_o[0], mism_o[0]}, {8'h01, 1'b0, 8'hC3});
      for (int i = 0; i < 12; i++) begin
         t = ($urandom_range(0, 3) == 0) ? 8'hC2 : 8'($urandom);
         repeat ($urandom_range(0, 3)) @(negedge clk);
         sweep(i % 2, 0, t, $urandom_range(0, 1) == 1, "rand");
      end
      reset = 1'b1;
      start_d[0] = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      start_d[0] = 1'b0;
      chk("rst_wins", {busy_o[0], rows[0], code_o[0]}, 0);
      @(negedge clk);
      chk("rst_wins_next", {busy_o[0], done_o[0]}, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/truth_table_sweeper.md
# truth_table_sweeper

- Sequential characterizer for the 3-input, 1-output logic functions in the Wolfram benchmark set.
- Drives all eight input rows into a combinational function-under-test and waits a programmable settle time per row.
- Samples the single output, assembles the 8-bit truth-table code (e.g. 8'hC2) and compares it with an expected code.
- Sits on the bench/characterization side, acting as the reader for the `in1/in2/in3 -> out` interface of each benchmark module.

## Interface
Parameters:
- SETTLE_CYCLES, default 4: cycles each row is held before sampling; legal range 1..255.
- EXPECTED, default 8'hC2: reference truth-table code.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  begin a sweep; sampled only in IDLE.
- in1  output  1  MSB of the applied row, to the function-under-test.
- in2  output  1  middle bit of the applied row.
- in3  output  1  LSB of the applied row.
- out  input  1  output of the function-under-test.
- busy  output  1  high from the cycle after start is accepted through the FINISH cycle.
- done  output  1  one-cycle pulse in FINISH.
- code  output  8  captured truth table; bit (7-k) is the output for row k = {in1,in2,in3}.
- match  output  1  (code == EXPECTED); valid from done, held until the next accepted start.
- mismatch  output  8  code XOR EXPECTED; same validity as match.

## Operation
- Reset values: all outputs 0; in1/in2/in3 = 3'b000; state IDLE.
- FSM states:
  - IDLE: inputs held at 000; start=1 -> SETTLE with row=0, settle count cleared, code/match/mismatch cleared.
  - SETTLE: {in1,in2,in3}=row; counts SETTLE_CYCLES cycles, then -> SAMPLE.
  - SAMPLE: {in1,in2,in3}=row; out is written into code[7-row] at the end of the cycle.
    - row<7: row++ and -> SETTLE.
    - row==7: -> FINISH.
  - FINISH: done=1, busy=1; match and mismatch are computed from the complete code; -> IDLE.
- start outside IDLE is ignored; no queuing.
- Row counter is 3 bits, and the sweep terminates on the row==7 check, never by wrap-around.
- code holds its value in IDLE until the next accepted start clears it.
- reset mid-sweep overrides everything the next edge: return to IDLE, inputs 000, code/match/mismatch cleared, no done pulse.
- reset and start asserted in the same cycle: reset wins.
- out is treated as already synchronous to clk; no synchronizer.

## Timing
- start sampled high in IDLE at edge 0 -> first SETTLE cycle is cycle 1, with row 0 applied.
- Each row occupies exactly SETTLE_CYCLES+1 cycles: SETTLE_CYCLES settle cycles plus one SAMPLE cycle.
- done is high in cycle 1 + 8·(SETTLE_CYCLES+1): cycle 41 for the default SETTLE_CYCLES=4. busy is low again in the following cycle.
- Back-to-back sweeps: start asserted in the cycle after done is accepted, so the minimum period is 8·(S+1)+2 cycles.
- Input changes happen only on the SAMPLE->SETTLE edge. The function-under-test therefore sees each row stable for S+1 cycles.

## Structure
- Shared package `tt_sweep_pkg` holds:
  - the state enum {IDLE, SETTLE, SAMPLE, FINISH};
  - the constant NUM_ROWS=8;
  - a function row_bit(row) returning 7-row, so that encoders and characterizers share one bit-ordering definition.
- One sub-module, `tt_settle_timer`: a loadable down-counter with load/expired signals, parameterized by SETTLE_CYCLES.
- The FSM, row counter and code register stay in the top level.

## Test plan
- DUT = m0xC2 model, S=4, pulse start:
  - row sequence 000..111, each row held 5 cycles;
  - done at cycle 41 with code=8'hC2, match=1, mismatch=8'h00.
- DUT = constant 1, EXPECTED=8'hC2 -> code=8'hFF, match=0, mismatch=8'h3D.
- S=1, DUT = in1 XOR in3:
  - code=8'h5A;
  - done at cycle 17;
  - start pulsed during busy is ignored, with no extra sweep and no duplicate done.
- reset asserted in row 3 SETTLE:
  - next cycle IDLE, inputs 000, busy=0, code=0;
  - no done pulse;
  - a new start completes normally.
- Two back-to-back sweeps with DUT changed from 0xC2 to 0x01 between sweeps:
  - second done yields code=8'h01;
  - match=0, mismatch=8'hC3;
  - the first result is held until the second start.
